// File: rtl/wave_column_scanner.sv
// wave_column_scanner: walks the logo ROM column by column and streams each
// column as a DISP_H-tall display column. Each column is shifted down by a
// triangle-wave offset, and the wave phase advances once per frame.
module wave_column_scanner #(
    parameter int LOGO_W     = 251,
    parameter int LOGO_H     = 38,
    parameter int AMP        = 5,
    parameter int COL_STEP   = 1,
    parameter int PHASE_STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic [9:0]        rom_col,
    input  logic [LOGO_H-1:0] rom_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic [5:0]        pix_row,
    output logic [9:0]        pix_col,
    output logic              pix_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int DISP_H = LOGO_H + 2*AMP;
    localparam int P      = 4*AMP;

    typedef enum logic [1:0] {IDLE, ADDR, EMIT} state_t;

    // Registered pixel-path response; every field holds while the consumer stalls.
    typedef struct packed {
        logic       valid;
        logic       data;
        logic [5:0] row;
        logic [9:0] col;
        logic       last;
    } pix_t;

    state_t            state, state_nxt;
    pix_t              pix_q;
    logic [LOGO_H-1:0] col_buf;
    logic [4:0]        phase, cphase, off;
    logic [4:0]        off_now;
    logic              start_ok, accept, row_end, col_end;

    // a + step, wrapped into 0..P-1 (step is reduced first so one subtract suffices)
    function automatic logic [4:0] add_mod(input logic [4:0] a, input int step);
        logic [5:0] s;
        s = {1'b0, a} + 6'(step % P);
        return (s >= 6'(P)) ? 5'(s - 6'(P)) : s[4:0];
    endfunction

    // Triangle wave: rises 0..2*AMP over the first half-period, falls back after
    function automatic logic [4:0] tri_off(input logic [4:0] cp);
        return (cp < 5'(2*AMP)) ? cp : 5'(P) - cp;
    endfunction

    // Display row r shows logo row r-o; rows above or below the logo are blank.
    // The r >= o test guards the unsigned subtract against wrap-around.
    function automatic logic pix_bit(input logic [LOGO_H-1:0] w,
                                     input logic [4:0]        o,
                                     input logic [5:0]        r);
        logic [5:0] lr;
        logic [5:0] idx;
        logic       b;
        lr  = r - 6'(o);
        idx = 6'(LOGO_H-1) - lr;
        b   = 1'b0;
        if ((r >= 6'(o)) && (lr < 6'(LOGO_H)))
            b = w[idx];
        return b;
    endfunction

    // A start pulse coinciding with frame_done is dropped, not queued.
    assign start_ok = (state == IDLE) && frame_start && !frame_done;
    assign accept   = pix_q.valid && pix_ready;
    assign row_end  = (pix_q.row == 6'(DISP_H-1));
    assign col_end  = (pix_q.col == 10'(LOGO_W-1));
    assign off_now  = tri_off(cphase);
    assign busy     = (state != IDLE);

    assign pix_valid = pix_q.valid;
    assign pix_data  = pix_q.data;
    assign pix_row   = pix_q.row;
    assign pix_col   = pix_q.col;
    assign pix_last  = pix_q.last;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: one ADDR cycle per column, then EMIT until the bottom row is taken
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = ADDR;
            ADDR:    state_nxt = EMIT;
            EMIT:    if (accept && row_end) state_nxt = col_end ? IDLE : ADDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: ROM addressing, column capture, wave phase and the pixel register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rom_col    <= '0;
            col_buf    <= '0;
            phase      <= '0;
            cphase     <= '0;
            off        <= '0;
            pix_q      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        rom_col <= '0;
                        cphase  <= phase;
                    end
                end
                ADDR: begin
                    // ROM is combinational: its word is valid in the same cycle,
                    // so row 0 is built straight from rom_data.
                    col_buf     <= rom_data;
                    off         <= off_now;
                    pix_q.valid <= 1'b1;
                    pix_q.data  <= pix_bit(rom_data, off_now, 6'd0);
                    pix_q.row   <= '0;
                    pix_q.col   <= rom_col;
                    pix_q.last  <= 1'b0;
                end
                EMIT: begin
                    if (accept) begin
                        if (!row_end) begin
                            pix_q.row  <= pix_q.row + 6'd1;
                            pix_q.data <= pix_bit(col_buf, off, pix_q.row + 6'd1);
                            pix_q.last <= col_end && (pix_q.row == 6'(DISP_H-2));
                        end else begin
                            pix_q.valid <= 1'b0;
                            pix_q.data  <= 1'b0;
                            pix_q.last  <= 1'b0;
                            if (col_end) begin
                                frame_done <= 1'b1;
                                phase      <= add_mod(phase, PHASE_STEP);
                            end else begin
                                rom_col <= rom_col + 10'd1;
                                cphase  <= add_mod(cphase, COL_STEP);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wave_column_scanner.sv
// tb_wave_column_scanner: drives whole frames against a behavioural model that
// places each logo column into a blank display column at its wave offset.
module tb_wave_column_scanner;

    localparam int LOGO_W     = 251;
    localparam int LOGO_H     = 38;
    localparam int AMP        = 5;
    localparam int COL_STEP   = 1;
    localparam int PHASE_STEP = 1;
    localparam int DISP_H     = LOGO_H + 2*AMP;
    localparam int P          = 4*AMP;

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic [9:0]        rom_col;
    logic [LOGO_H-1:0] rom_data;
    logic              pix_valid;
    logic              pix_ready;
    logic              pix_data;
    logic [5:0]        pix_row;
    logic [9:0]        pix_col;
    logic              pix_last;
    logic              busy;
    logic              frame_done;

    logic [LOGO_H-1:0] rom_mem [0:LOGO_W-1];
    int                n_cmp;
    int                n_bad;
    int                m_phase;

    wave_column_scanner #(
        .LOGO_W(LOGO_W), .LOGO_H(LOGO_H), .AMP(AMP),
        .COL_STEP(COL_STEP), .PHASE_STEP(PHASE_STEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .rom_col(rom_col), .rom_data(rom_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // combinational logo ROM
    assign rom_data = (rom_col < 10'(LOGO_W)) ? rom_mem[rom_col[7:0]] : '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp,
                         input int c, input int r);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s col %0d row %0d: observed %0h expected %0h", tag, c, r, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},  64'(busy),       64'd0, -1, -1);
        check({tag, "_valid"}, 64'(pix_valid),  64'd0, -1, -1);
        check({tag, "_data"},  64'(pix_data),   64'd0, -1, -1);
        check({tag, "_last"},  64'(pix_last),   64'd0, -1, -1);
        check({tag, "_done"},  64'(frame_done), 64'd0, -1, -1);
        check({tag, "_romcol"},64'(rom_col),    64'd0, -1, -1);
        check({tag, "_pixcol"},64'(pix_col),    64'd0, -1, -1);
        check({tag, "_pixrow"},64'(pix_row),    64'd0, -1, -1);
    endtask

    // One frame. stall_col/stray_col/abort_col < 0 disable those disturbances.
    task automatic run_frame(input int ready_pct, input int stall_col, input int stray_col,
                             input int abort_col, input bit start_on_done);
        int                idx, c, r, t, off, cyc, last_cyc;
        bit                stop, stalled, strayed, aborted, timed_out;
        logic [DISP_H-1:0] disp;
        logic [LOGO_H-1:0] w;
        logic              exp_last;
        idx = 0; cyc = 0; last_cyc = 0;
        stop = 0; stalled = 0; strayed = 0; aborted = 0; timed_out = 0;
        @(negedge clk);
        frame_start = 1'b1;
        pix_ready   = 1'b0;
        @(negedge clk);
        frame_start = 1'b0;
        check("start_busy",   64'(busy),      64'd1, 0, 0);
        check("start_romcol", 64'(rom_col),   64'd0, 0, 0);
        check("start_valid",  64'(pix_valid), 64'd0, 0, 0);
        while (!stop) begin
            c = idx / DISP_H;
            r = idx % DISP_H;
            t   = (m_phase + c*COL_STEP) % P;
            off = (t <= 2*AMP) ? t : P - t;
            w   = rom_mem[c];
            disp = '0;
            for (int lr = 0; lr < LOGO_H; lr++) disp[lr+off] = w[LOGO_H-1-lr];
            exp_last = (c == LOGO_W-1) && (r == DISP_H-1);
            frame_start = 1'b0;
            if (cyc == 1) check("first_valid", 64'(pix_valid), 64'd1, c, r);
            if (c == abort_col && pix_valid) begin
                rst_n = 1'b0;
                pix_ready = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                aborted = 1;
                stop = 1;
            end else begin
                if (c == stall_col && r == 10 && pix_valid && !stalled) begin
                    stalled = 1;
                    for (int k = 0; k < 5; k++) begin
                        pix_ready = 1'b0;
                        @(negedge clk);
                        cyc++;
                        check("stall_hold", 64'({pix_valid, pix_data, pix_row, pix_col, pix_last}),
                              64'({1'b1, disp[r], 6'(r), 10'(c), exp_last}), c, r);
                    end
                end
                if (c == stray_col && r == 5 && !strayed) begin
                    frame_start = 1'b1;
                    strayed = 1;
                end
                pix_ready = ($urandom_range(0, 99) < ready_pct);
                if (pix_valid && pix_ready) begin
                    check("pix_col",  64'(pix_col),  64'(c),        c, r);
                    check("pix_row",  64'(pix_row),  64'(r),        c, r);
                    check("pix_data", 64'(pix_data), 64'(disp[r]),  c, r);
                    check("pix_last", 64'(pix_last), 64'(exp_last), c, r);
                    last_cyc = cyc;
                    idx++;
                    if (idx == LOGO_W*DISP_H) stop = 1;
                end
                @(negedge clk);
                cyc++;
                if (!stop && cyc > 40000) begin
                    check("timeout_accepts", 64'(idx), 64'(LOGO_W*DISP_H), c, r);
                    timed_out = 1;
                    stop = 1;
                end
            end
        end
        frame_start = 1'b0;
        pix_ready   = 1'b0;
        if (aborted) begin
            check_idle("abort");
            m_phase = 0;
        end else if (!timed_out) begin
            check("done_pulse", 64'(frame_done), 64'd1, -1, -1);
            check("done_busy",  64'(busy),       64'd0, -1, -1);
            check("done_valid", 64'(pix_valid),  64'd0, -1, -1);
            if (ready_pct == 100)
                check("frame_len", 64'(last_cyc + 1), 64'(LOGO_W*(DISP_H+1)), -1, -1);
            m_phase = (m_phase + PHASE_STEP) % P;
            if (start_on_done) frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
            check("done_once",   64'(frame_done), 64'd0, -1, -1);
            check("start_at_done_ignored", 64'(busy), 64'd0, -1, -1);
        end
    endtask

    // Directed sequence of frames
    initial begin
        n_cmp = 0; n_bad = 0; m_phase = 0;
        rst_n = 1'b0; frame_start = 1'b0; pix_ready = 1'b0;
        for (int c = 0; c < LOGO_W; c++) rom_mem[c] = '1;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;

        // frame 0: all-ones logo, free-running consumer
        run_frame(100, -1, -1, -1, 1'b0);
        // frame 1: phase advanced by one; start pulse on the frame_done cycle
        run_frame(100, -1, -1, -1, 1'b1);

        // frame 2: random logo, random backpressure, a forced 5-cycle stall,
        // and a stray start request mid-frame
        for (int c = 0; c < LOGO_W; c++) rom_mem[c] = LOGO_H'({$urandom(), $urandom()});
        run_frame(80, 57, 130, -1, 1'b0);

        // frame 3: top/bottom logo rows only, aborted by reset at column 100
        for (int c = 0; c < LOGO_W; c++) rom_mem[c] = 38'h2000000001;
        run_frame(80, -1, -1, 100, 1'b0);
        // frame 4: restarts from column 0 with phase back at 0
        run_frame(80, 3, -1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wave_column_scanner.md
# wave_column_scanner

Streams the 251×38 logo bitmap to the display pixel path one pixel at a time, applying a travelling triangle-wave vertical offset to each column. It drives the column index into the logo ROM and captures the 38-bit column word the ROM returns. It then shifts that column into a taller display column and emits its pixels over a valid/ready handshake. A per-frame phase counter makes the wave travel across the logo.

## Interface
- LOGO_W, 251, logo columns (ROM column index range 0..LOGO_W-1)
- LOGO_H, 38, logo rows (ROM data width)
- AMP, 5, wave half-amplitude; display column height DISP_H = LOGO_H + 2*AMP = 48
- COL_STEP, 1, wave-phase increment per column, modulo 4*AMP
- PHASE_STEP, 1, wave-phase increment per frame, modulo 4*AMP

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset; synchronous, active-low
- frame_start  in  1  one-cycle request to scan one frame
- rom_col  out  10  column index to logo ROM
- rom_data  in  LOGO_H  ROM column word; bit LOGO_H-1 = top logo row
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_data  out  1  pixel value
- pix_row  out  6  display row 0..DISP_H-1, 0 = top
- pix_col  out  10  display column 0..LOGO_W-1
- pix_last  out  1  high with final pixel of frame
- busy  out  1  high when state ≠ IDLE
- frame_done  out  1  one-cycle pulse after final pixel accepted

## Operation
- FSM states:
  - IDLE: waits for frame_start.
  - ADDR: rom_col is stable for one cycle. At the end of the cycle, rom_data is captured into col_buf, the column offset is registered, and the FSM goes to EMIT.
  - EMIT: presents pixels. It stays in EMIT until row DISP_H-1 is accepted.
    - If the column was not the last, it increments the column and goes to ADDR.
    - If the column was the last, it goes to IDLE.
- Wave arithmetic, all terms modulo P = 4*AMP, using 5-bit registers:
  - phase: per-frame register.
  - cphase: reloads from phase at frame start and adds COL_STEP per column, wrapping at P.
  - Column offset off = cphase if cphase < 2*AMP, else P − cphase. Range 0..2*AMP.
- Pixel rule for display row r with lr = r − off:
  - pix_data = col_buf[LOGO_H-1-lr] when 0 ≤ lr < LOGO_H.
  - pix_data = 0 otherwise. The comparison is signed, or uses r ≥ off.
- phase += PHASE_STEP mod P when frame_done pulses.
- frame_start is honoured only in IDLE. It is ignored while busy and is not queued.
- frame_start in the same cycle as frame_done's return to IDLE is ignored; it is accepted from the following cycle.
- rom_col holds its last value while IDLE. The ROM is combinational, so there is no wait state beyond ADDR.

## Timing
- Reset values, with rst_n low at a clk edge:
  - state IDLE.
  - rom_col, pix_col, pix_row, phase, cphase all 0.
  - pix_valid, pix_data, pix_last, busy, frame_done all 0.
- Reset mid-frame aborts immediately. phase is reset to 0, not advanced.
- frame_start sampled at edge N → ADDR at N+1 (busy=1, rom_col=0) → first pix_valid at N+2.
- Handshake: a pixel transfers on a cycle with pix_valid & pix_ready.
  - While pix_ready=0, pix_valid, pix_data, pix_row, pix_col and pix_last hold stable.
  - pix_valid never drops before acceptance.
- Throughput: one pixel per cycle within a column. Each column boundary costs one bubble cycle (ADDR).
- Frame length with pix_ready tied 1: LOGO_W*(DISP_H+1) = 12299 cycles from ADDR entry to the last accept.
- pix_last=1 only at pix_col=LOGO_W-1 and pix_row=DISP_H-1.
- frame_done pulses the cycle after that accept, with state IDLE and busy=0 in the same cycle.

## Test plan
- **Reset and first column.** Drive rom_data = all ones, pix_ready=1, frame_start once after reset.
  - rom_col=0 one cycle after frame_start.
  - Column 0 (off=0): rows 0..37 = 1, rows 38..47 = 0.
  - First pix_valid two cycles after frame_start.
- **Wave shape in frame 0.** Use the same stimulus.
  - Column 3: off=3, rows 3..40 = 1.
  - Column 12: cphase=12, off=8, rows 8..45 = 1.
  - Column 20: cphase wraps to 0, off=0.
- **Phase advance.** Run a second frame.
  - Column 0 off=1, rows 1..38 = 1.
  - pix_last on exactly the 12048th accept.
  - frame_done one cycle later.
- **Backpressure.** In EMIT, hold pix_ready=0 for 5 cycles.
  - All pixel outputs are stable for those 5 cycles.
  - There is no skipped or duplicated row; the bench checks the row sequence 0..47 per column.
- **Bit ordering.** rom_data = 38'h2000000001 (top and bottom logo rows set), frame 0.
  - Column 0: pixel 1 only at rows 0 and 37.
- **Control corners.**
  - frame_start pulsed mid-frame: no effect on the pixel sequence.
  - rst_n low at column 100: next cycle idle outputs; a later frame restarts at column 0 with phase=0.
